// File: rtl/tictactoe_pkg.sv
// Shared definitions for the tic-tac-toe move scanner: cell codes,
// scanner state type and the "no cell" address marker.
package tictactoe_pkg;

    // Two-bit cell codes; only CELL_EMPTY marks a free cell, every other code is occupied
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b11;
    localparam logic [1:0] CELL_P2    = 2'b10;

    // Scanner control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    // All-ones address marker; users slice it down to their own address width
    localparam logic [7:0] BAD_ADDR = 8'hFF;

    // True when a cell code means the square is free
    function automatic logic isEmptyCode(input logic [1:0] code);
        return (code == CELL_EMPTY);
    endfunction

endpackage

// File: rtl/move_scan_ai_board_cell_sel.sv
// Combinational cell picker: returns whether the cell at a given index of a
// packed board is empty.
module board_cell_sel
    import tictactoe_pkg::*;
#(
    parameter int N  = 3,
    parameter int AW = $clog2(N*N)
) (
    input  logic [2*N*N-1:0] board,
    input  logic [AW-1:0]    index,
    output logic             is_empty
);

    logic [1:0] w_cell;

    // Mux the addressed 2-bit cell out of the board; unreachable indices read as occupied
    always_comb begin
        w_cell = CELL_P1;
        for (int i = 0; i < N*N; i++) begin
            if (index == i[AW-1:0]) begin
                w_cell = board[2*i +: 2];
            end
        end
    end

    assign is_empty = isEmptyCode(w_cell);

endmodule

// File: rtl/move_scan_ai.sv
// Move scanner: captures a board snapshot on start, then walks the cells one
// per cycle (wrapping) from a chosen start cell until it finds an empty one or
// has looked at every cell, and reports the result with a one-cycle done pulse.
module move_scan_ai
    import tictactoe_pkg::*;
#(
    parameter int N  = 3,
    parameter int AW = $clog2(N*N)
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             start,
    input  logic             from_origin,
    input  logic [AW-1:0]    origin,
    input  logic [2*N*N-1:0] gBoard,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [AW-1:0]    addr
);

    localparam logic [AW:0]   CELLS    = (AW+1)'(N*N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N*N - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [AW-1:0] NO_CELL  = BAD_ADDR[AW-1:0];

    scan_state_t        r_state;
    logic [2*N*N-1:0]   r_board;
    logic [AW-1:0]      r_index;
    logic [AW-1:0]      r_count;
    logic               r_busy;
    logic               r_done;
    logic               r_donePend;
    logic               r_found;
    logic [AW-1:0]      r_addr;

    logic [AW-1:0]      w_startIdx;
    logic [AW-1:0]      w_nextIdx;
    logic               w_isEmpty;

    // Start cell: the requested origin when it names a real cell, otherwise cell 0
    always_comb begin
        w_startIdx = '0;
        if (from_origin && ({1'b0, origin} < CELLS)) begin
            w_startIdx = origin;
        end
    end

    // Next cell to examine, wrapping explicitly after the last cell
    always_comb begin
        w_nextIdx = r_index + ONE;
        if (r_index == LAST_IDX) begin
            w_nextIdx = '0;
        end
    end

    board_cell_sel #(
        .N  (N),
        .AW (AW)
    ) u_cellSel (
        .board    (r_board),
        .index    (r_index),
        .is_empty (w_isEmpty)
    );

    // Scan FSM with registered outputs; done trails the entry into DONE by one cycle
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_board    <= '0;
            r_index    <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_donePend <= 1'b0;
            r_found    <= 1'b0;
            r_addr     <= NO_CELL;
        end else begin
            r_done     <= r_donePend;
            r_donePend <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_SCAN;
                        r_busy  <= 1'b1;
                        r_board <= gBoard;
                        r_index <= w_startIdx;
                        r_count <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (w_isEmpty) begin
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_found    <= 1'b1;
                        r_addr     <= r_index;
                        r_donePend <= 1'b1;
                    end else if (r_count == LAST_IDX) begin
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_found    <= 1'b0;
                        r_addr     <= NO_CELL;
                        r_donePend <= 1'b1;
                    end else begin
                        r_index <= w_nextIdx;
                        r_count <= r_count + ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign found = r_found;
    assign addr  = r_addr;

endmodule

// File: tb/tb_move_scan_ai.sv
// Bench for move_scan_ai (N=3): directed scans with hand-computed latencies and
// results, plus a cycle-by-cycle comparison against a behavioural scan model.
module tb_move_scan_ai;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int NC = N*N;

    logic          ph1;
    logic          reset;
    logic          start;
    logic          from_origin;
    logic [AW-1:0] origin;
    logic [2*NC-1:0] gBoard;
    logic          busy;
    logic          done;
    logic          found;
    logic [AW-1:0] addr;

    int testsRun  = 0;
    int testsFail = 0;

    move_scan_ai #(.N(N), .AW(AW)) dut (
        .ph1         (ph1),
        .reset       (reset),
        .start       (start),
        .from_origin (from_origin),
        .origin      (origin),
        .gBoard      (gBoard),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .addr        (addr)
    );

    // Free-running clock
    initial begin
        ph1 = 1'b0;
        forever #5 ph1 = ~ph1;
    end

    // Behavioural scan model: picks the first free cell walking forward with
    // modulo wrap, then derives when each output must change from the hit count
    int            cyc      = 0;
    bit            active   = 1'b0;
    int            tStart   = 0;
    int            kHit     = 0;
    bit            pendFound = 1'b0;
    logic [AW-1:0] pendAddr = 4'hF;
    bit            mBusy    = 1'b0;
    bit            mDone    = 1'b0;
    bit            mFound   = 1'b0;
    logic [AW-1:0] mAddr    = 4'hF;

    task automatic scanModel(input logic [2*NC-1:0] b, input bit fo, input logic [AW-1:0] org,
                             output int k, output bit f, output logic [AW-1:0] a);
        int s;
        s = (fo && org < NC) ? int'(org) : 0;
        k = NC;
        f = 1'b0;
        a = 4'hF;
        for (int j = 0; j < NC; j++) begin
            int idx;
            idx = (s + j) % NC;
            if (b[2*idx +: 2] == 2'b00) begin
                k = j + 1;
                f = 1'b1;
                a = idx[AW-1:0];
                break;
            end
        end
    endtask

    always @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            active = 1'b0;
            mBusy  = 1'b0;
            mDone  = 1'b0;
            mFound = 1'b0;
            mAddr  = 4'hF;
        end else begin
            cyc++;
            mDone = active && (cyc - tStart == kHit + 1);
            if (active && (cyc - tStart == kHit)) begin
                mFound = pendFound;
                mAddr  = pendAddr;
            end
            if (start && !(active && (cyc - tStart <= kHit))) begin
                active = 1'b1;
                tStart = cyc;
                scanModel(gBoard, from_origin, origin, kHit, pendFound, pendAddr);
            end
            mBusy = active && (cyc - tStart < kHit);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the clock edge
    task automatic compareLoop();
        forever begin
            @(negedge ph1);
            checkOutput("cyc_busy",  {31'd0, busy},  {31'd0, mBusy});
            checkOutput("cyc_done",  {31'd0, done},  {31'd0, mDone});
            checkOutput("cyc_found", {31'd0, found}, {31'd0, mFound});
            checkOutput("cyc_addr",  {28'd0, addr},  {28'd0, mAddr});
        end
    endtask

    // Drive a one-cycle start; returns 1 time unit after the start edge
    task automatic startScan(input logic [2*NC-1:0] b, input bit fo, input logic [AW-1:0] org);
        gBoard      = b;
        from_origin = fo;
        origin      = org;
        start       = 1'b1;
        @(posedge ph1);
        #1;
        start = 1'b0;
    endtask

    // Count cycles from the start edge until done, bounded
    task automatic waitDone(output int lat);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge ph1);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input string name, input logic [2*NC-1:0] b, input bit fo,
                                 input logic [AW-1:0] org, input int expLat,
                                 input bit expFound, input logic [AW-1:0] expAddr);
        int lat;
        startScan(b, fo, org);
        waitDone(lat);
        checkOutput({name, "_latency"}, lat, expLat);
        checkOutput({name, "_found"}, {31'd0, found}, {31'd0, expFound});
        checkOutput({name, "_addr"}, {28'd0, addr}, {28'd0, expAddr});
        @(posedge ph1);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        from_origin = 1'b0;
        origin      = '0;
        gBoard      = '0;
        fork
            compareLoop();
            begin
                int lat;
                int nDone;
                int firstLat;
                bit dropped;

                // Reset values
                repeat (2) @(posedge ph1);
                #1;
                checkOutput("rst_busy",  {31'd0, busy},  32'd0);
                checkOutput("rst_done",  {31'd0, done},  32'd0);
                checkOutput("rst_found", {31'd0, found}, 32'd0);
                checkOutput("rst_addr",  {28'd0, addr},  32'hF);
                reset = 1'b1;
                @(posedge ph1);
                #1;

                // Empty board from the centre
                applyStimulus("empty_o4", 18'd0, 1'b1, 4'd4, 2, 1'b1, 4'd4);
                // Cells 4..8 occupied (one with code 01), wrap from 6 to cell 0
                applyStimulus("wrap_o6", {2'b11, 2'b10, 2'b01, 2'b11, 2'b10, 8'h00}, 1'b1, 4'd6, 5, 1'b1, 4'd0);
                // Scan from cell 0 ignoring origin
                applyStimulus("zero_start", {14'd0, 2'b11, 2'b10}, 1'b0, 4'd7, 4, 1'b1, 4'd2);
                // Full board
                applyStimulus("full", 18'b11_10_11_10_11_10_11_10_11, 1'b1, 4'd4, 10, 1'b0, 4'hF);
                // Out-of-range origin falls back to cell 0
                applyStimulus("bad_origin", {16'd0, 2'b11}, 1'b1, 4'd12, 3, 1'b1, 4'd1);

                // Board changed and start re-pulsed mid-scan
                startScan({8'h00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10}, 1'b0, 4'd0);
                nDone    = 0;
                firstLat = 0;
                for (int c = 1; c <= 14; c++) begin
                    @(posedge ph1);
                    #1;
                    if (c == 1) begin
                        gBoard = '0;
                        start  = 1'b1;
                    end
                    if (c == 2) start = 1'b0;
                    if (done) begin
                        nDone++;
                        if (firstLat == 0) firstLat = c;
                    end
                end
                checkOutput("midscan_latency", firstLat, 7);
                checkOutput("midscan_pulses", nDone, 1);
                checkOutput("midscan_addr", {28'd0, addr}, 32'd5);

                // Reset in the middle of a scan
                startScan(18'b11_10_11_10_11_10_11_10_11, 1'b1, 4'd0);
                repeat (3) @(posedge ph1);
                #1;
                reset = 1'b0;
                #1;
                checkOutput("midrst_busy",  {31'd0, busy},  32'd0);
                checkOutput("midrst_done",  {31'd0, done},  32'd0);
                checkOutput("midrst_found", {31'd0, found}, 32'd0);
                checkOutput("midrst_addr",  {28'd0, addr},  32'hF);
                nDone = 0;
                repeat (3) begin
                    @(posedge ph1);
                    #1;
                    if (done) nDone++;
                end
                reset = 1'b1;
                repeat (12) begin
                    @(posedge ph1);
                    #1;
                    if (done) nDone++;
                end
                checkOutput("midrst_no_done", nDone, 0);
                applyStimulus("after_rst", 18'd0, 1'b1, 4'd4, 2, 1'b1, 4'd4);

                // Restart straight from DONE
                startScan(18'b11_11_11_11_11_00_10_10_10, 1'b1, 4'd3);
                dropped = 1'b0;
                for (int c = 0; c < 12; c++) begin
                    if (!busy) begin
                        dropped = 1'b1;
                        break;
                    end
                    @(posedge ph1);
                    #1;
                end
                checkOutput("done_restart_busy_drop", {31'd0, dropped}, 32'd1);
                checkOutput("done_restart_first_addr", {28'd0, addr}, 32'd3);
                startScan({2'b00, 16'hFFFF}, 1'b1, 4'd0);
                waitDone(lat);
                checkOutput("done_restart_latency", lat, 10);
                checkOutput("done_restart_addr", {28'd0, addr}, 32'd8);
                checkOutput("done_restart_found", {31'd0, found}, 32'd1);
                repeat (3) @(posedge ph1);
                #1;
            end
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
